// File: rtl/irq_pending_collector.sv
// irq_pending_collector: sticky 16-line request collector feeding an external
// 16-bit priority encoder. It presents the encoder's winning index over a
// valid/ready handshake and clears the serviced bit on acceptance.
// Optional feature macro: IRQ_EDGE_DETECT_EN. When it is defined, only rising
// edges of the request lines set pending bits. When it is undefined, the
// request lines are level-sensitive.
module irq_pending_collector #(
  parameter logic [7:0] EMPTY_CODE = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       clr_all,
  output logic [7:0] pend_a,
  output logic [7:0] pend_b,
  input  logic [7:0] code_in,
  output logic       irq_valid,
  output logic [3:0] irq_code,
  input  logic       irq_ready,
  output logic       err
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pending;
  logic [15:0] req_vec;
  logic [15:0] new_req;
  logic [15:0] clr_mask;
  logic        code_legal;
  logic        accept;

  assign req_vec    = {req_a, req_b};
  assign pend_a     = pending[15:8];
  assign pend_b     = pending[7:0];
  assign code_legal = (code_in < 8'd16);
  assign accept     = (state == PRESENT) && irq_ready;
  assign irq_valid  = (state == PRESENT);

`ifdef IRQ_EDGE_DETECT_EN
  logic [15:0] req_q;

  // Request history for rising-edge detection. It keeps updating through
  // clr_all, so a flush does not produce false edges afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_vec;
    end
  end

  assign new_req = req_vec & ~req_q;
`else
  assign new_req = req_vec;
`endif

  // One-hot clear of the index being accepted in this cycle.
  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask = 16'(1) << irq_code;
    end
  end

  // Pending mask. A set and a clear of the same bit in one cycle leave the bit set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (clr_all) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | new_req;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. While an index is being presented, code_in is ignored.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (code_legal) state_next = PRESENT;
      PRESENT: if (irq_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr_all) begin
      state_next = IDLE;
    end
  end

  // Winning index. It is captured only on entry to PRESENT and held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_code <= '0;
    end else if (!clr_all && (state == IDLE) && code_legal) begin
      irq_code <= code_in[3:0];
    end
  end

  // Sticky flag for an illegal encoder code seen in IDLE. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == IDLE) && !code_legal && (code_in != EMPTY_CODE)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_pending_collector.sv
// Directed self-checking bench for irq_pending_collector. It includes a small
// priority-encoder model in which the highest set bit wins.
module tb_irq_pending_collector;

  localparam logic [7:0] EMPTY = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       clr_all;
  logic [7:0] pend_a;
  logic [7:0] pend_b;
  logic [7:0] code_in;
  logic       irq_valid;
  logic [3:0] irq_code;
  logic       irq_ready;
  logic       err;

  logic       force_en;
  logic [7:0] force_val;
  logic [7:0] enc_code;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic        counting = 1'b0;
  int unsigned grants = 0;
  int unsigned bad_codes = 0;

  always #5 clk = ~clk;

  irq_pending_collector #(.EMPTY_CODE(EMPTY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .clr_all  (clr_all),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .code_in  (code_in),
    .irq_valid(irq_valid),
    .irq_code (irq_code),
    .irq_ready(irq_ready),
    .err      (err)
  );

  // Encoder model: report the highest set bit of the pending mask, or EMPTY.
  always_comb begin
    logic [15:0] p;
    p = {pend_a, pend_b};
    enc_code = EMPTY;
    for (int i = 0; i < 16; i++) begin
      if (p[i] === 1'b1) enc_code = 8'(i);
    end
  end

  assign code_in = force_en ? force_val : enc_code;

  // Count accepted grants: valid and ready are stable mid-cycle and complete at the next edge.
  always @(negedge clk) begin
    if (counting && rst_n && !clr_all && irq_valid && irq_ready) begin
      grants++;
      if (irq_code !== 4'd2) bad_codes++;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_a = '0; req_b = '0; clr_all = 1'b0;
    irq_ready = 1'b1; force_en = 1'b0; force_val = '0;
    tick(2);
    check_val("rst_pend",  {pend_a, pend_b}, 16'h0000);
    check_val("rst_valid", 16'(irq_valid), 16'h0);
    check_val("rst_code",  16'(irq_code), 16'h0);
    check_val("rst_err",   16'(err), 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Single request on line 0: pending after 1 cycle, valid after 2.
    req_b = 8'h01;
    tick();
    check_val("t1_pend_b", 16'(pend_b), 16'h0001);
    check_val("t1_valid0", 16'(irq_valid), 16'h0);
    req_b = 8'h00;
    tick();
    check_val("t1_valid",  16'(irq_valid), 16'h1);
    check_val("t1_code",   16'(irq_code), 16'h0);
    tick();
    check_val("t1_clear",  16'(pend_b), 16'h0000);
    check_val("t1_idle",   16'(irq_valid), 16'h0);

    // Lines 15 and 3 together: 15 is granted first, then 3 two cycles later.
    req_a = 8'h80; req_b = 8'h08;
    tick();
    req_a = 8'h00; req_b = 8'h00;
    check_val("t2_pend",   {pend_a, pend_b}, 16'h8008);
    tick();
    check_val("t2_code15", 16'(irq_code), 16'd15);
    check_val("t2_valid1", 16'(irq_valid), 16'h1);
    tick();
    check_val("t2_gap",    16'(irq_valid), 16'h0);
    check_val("t2_pend2",  {pend_a, pend_b}, 16'h0008);
    tick();
    check_val("t2_code3",  16'(irq_code), 16'd3);
    check_val("t2_valid2", 16'(irq_valid), 16'h1);
    tick();
    check_val("t2_empty",  {pend_a, pend_b}, 16'h0000);

    // Held index: code 5 is presented and a later line 12 must not preempt it.
    irq_ready = 1'b0;
    req_b = 8'h20;
    tick();
    req_b = 8'h00;
    tick();
    check_val("t3_code5",  16'(irq_code), 16'd5);
    req_a = 8'h10;
    tick();
    req_a = 8'h00;
    check_val("t3_hold_a", 16'(irq_code), 16'd5);
    check_val("t3_pend",   {pend_a, pend_b}, 16'h1020);
    tick();
    check_val("t3_hold_b", 16'(irq_code), 16'd5);
    check_val("t3_hold_v", 16'(irq_valid), 16'h1);
    irq_ready = 1'b1;
    tick();
    check_val("t3_acc",    16'(irq_valid), 16'h0);
    tick();
    check_val("t3_code12", 16'(irq_code), 16'd12);
    tick();
    check_val("t3_empty",  {pend_a, pend_b}, 16'h0000);
    tick(2);

    // Line 2 held high for 10 cycles with the consumer always ready.
    counting = 1'b1;
    req_b = 8'h04;
    tick(10);
    req_b = 8'h00;
    tick(6);
    counting = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    check_val("t4_grants", 16'(grants), 16'd1);
`else
    check_val("t4_grants", 16'(grants), 16'd5);
`endif
    check_val("t4_codes",  16'(bad_codes), 16'd0);
    check_val("t4_empty",  {pend_a, pend_b}, 16'h0000);

    // Illegal encoder code in IDLE sets err; clr_all does not clear it.
    force_en = 1'b1; force_val = 8'h20;
    tick();
    force_en = 1'b0;
    check_val("t5_err",    16'(err), 16'h1);
    check_val("t5_valid",  16'(irq_valid), 16'h0);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check_val("t5_err_clr", 16'(err), 16'h1);

    // clr_all while presenting with pending = 0x0410.
    irq_ready = 1'b0;
    req_a = 8'h04; req_b = 8'h10;
    tick();
    req_a = 8'h00; req_b = 8'h00;
    tick();
    check_val("t6_code10", 16'(irq_code), 16'd10);
    check_val("t6_pend",   {pend_a, pend_b}, 16'h0410);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check_val("t6_cvalid", 16'(irq_valid), 16'h0);
    check_val("t6_cpend",  {pend_a, pend_b}, 16'h0000);
    check_val("t6_cerr",   16'(err), 16'h1);

    // The same scenario, this time aborted by reset.
    req_a = 8'h04; req_b = 8'h10;
    tick();
    req_a = 8'h00; req_b = 8'h00;
    tick();
    check_val("t6_valid2", 16'(irq_valid), 16'h1);
    rst_n = 1'b0;
    tick();
    check_val("t6_rpend",  {pend_a, pend_b}, 16'h0000);
    check_val("t6_rvalid", 16'(irq_valid), 16'h0);
    check_val("t6_rcode",  16'(irq_code), 16'h0);
    check_val("t6_rerr",   16'(err), 16'h0);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
